// File: rtl/eqv_response_checker.sv
// Sequential response checker: compares golden vs simplified netlist responses per
// accepted beat, counts mismatches, captures the first failure and compacts dut_out into a MISR.
module eqv_response_checker #(
  parameter int          CNT_W = 16,
  parameter logic [15:0] POLY  = 16'h100B,
  parameter logic [15:0] SEED  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_vec,
  input  logic [3:0]       gold_out,
  input  logic [3:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [11:0]      first_fail_vec,
  output logic [3:0]       first_fail_gold,
  output logic [3:0]       first_fail_dut,
  output logic [15:0]      signature
);

  // Handshake: a beat transfers on any cycle with in_valid && in_ready. in_ready is a
  // pure decode of the registered state, so it never depends on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [11:0]      ff_vec_q, ff_vec_d;
  logic [3:0]       ff_gold_q, ff_gold_d;
  logic [3:0]       ff_dut_q, ff_dut_d;
  logic [15:0]      sig_q, sig_d;

  logic start_acc;
  logic beat;
  logic mismatch;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    fail_count_d = fail_count_q;
    seen_d       = seen_q;
    ff_idx_d     = ff_idx_q;
    ff_vec_d     = ff_vec_q;
    ff_gold_d    = ff_gold_q;
    ff_dut_d     = ff_dut_q;
    sig_d        = sig_q;

    start_acc = start && (state_q != S_RUN);
    beat      = (state_q == S_RUN) && in_valid;
    mismatch  = (gold_out != dut_out);

    if (start_acc) begin
      state_d      = (num_vectors == '0) ? S_DONE : S_RUN;
      num_d        = num_vectors;
      idx_d        = '0;
      fail_count_d = '0;
      seen_d       = 1'b0;
      ff_idx_d     = '0;
      ff_vec_d     = '0;
      ff_gold_d    = '0;
      ff_dut_d     = '0;
      sig_d        = SEED;
    end else if (beat) begin
      idx_d = idx_q + ONE;
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {12'h000, dut_out};
      if (mismatch && (fail_count_q != '1)) begin
        fail_count_d = fail_count_q + ONE;
      end
      if (mismatch && !seen_q) begin
        seen_d    = 1'b1;
        ff_idx_d  = idx_q;
        ff_vec_d  = in_vec;
        ff_gold_d = gold_out;
        ff_dut_d  = dut_out;
      end
      if (idx_q == (num_q - ONE)) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      idx_q        <= '0;
      fail_count_q <= '0;
      seen_q       <= 1'b0;
      ff_idx_q     <= '0;
      ff_vec_q     <= '0;
      ff_gold_q    <= '0;
      ff_dut_q     <= '0;
      sig_q        <= SEED;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      fail_count_q <= fail_count_d;
      seen_q       <= seen_d;
      ff_idx_q     <= ff_idx_d;
      ff_vec_q     <= ff_vec_d;
      ff_gold_q    <= ff_gold_d;
      ff_dut_q     <= ff_dut_d;
      sig_q        <= sig_d;
    end
  end

  assign in_ready        = (state_q == S_RUN);
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) && (fail_count_q == '0);
  assign fail_count      = fail_count_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_gold = ff_gold_q;
  assign first_fail_dut  = ff_dut_q;
  assign signature       = sig_q;

endmodule

// File: tb/tb_eqv_response_checker.sv
// Directed bench for eqv_response_checker with hand-computed expected values.
module tb_eqv_response_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_vec;
  logic [3:0]  gold_out;
  logic [3:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] fail_count;
  logic [15:0] first_fail_idx;
  logic [11:0] first_fail_vec;
  logic [3:0]  first_fail_gold;
  logic [3:0]  first_fail_dut;
  logic [15:0] signature;

  int n_checks = 0;
  int n_errors = 0;

  eqv_response_checker dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_vectors     (num_vectors),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vec          (in_vec),
    .gold_out        (gold_out),
    .dut_out         (dut_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_idx  (first_fail_idx),
    .first_fail_vec  (first_fail_vec),
    .first_fail_gold (first_fail_gold),
    .first_fail_dut  (first_fail_dut),
    .signature       (signature)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_vectors = n;
    step();
    start       = 1'b0;
  endtask

  task automatic send_beat(input logic [11:0] v, input logic [3:0] g, input logic [3:0] d);
    in_valid = 1'b1;
    in_vec   = v;
    gold_out = g;
    dut_out  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vectors = '0;
    in_valid = 1'b0; in_vec = '0; gold_out = '0; dut_out = '0;
    #2;
    step(); step();
    rst = 1'b0;

    // reset state
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_fail_count", fail_count, 0);
    check_eq("rst_signature", signature, 16'h0000);

    // four matching beats
    do_start(16'd4);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_in_ready", in_ready, 1);
    send_beat(12'h001, 4'h1, 4'h1);
    send_beat(12'h002, 4'h0, 4'h0);
    send_beat(12'h003, 4'h0, 4'h0);
    check_eq("t1_not_done_early", done, 0);
    send_beat(12'h004, 4'h0, 4'h0);
    check_eq("t1_done", done, 1);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_fail_count", fail_count, 0);
    check_eq("t1_signature", signature, 16'h0008);
    check_eq("t1_in_ready_low", in_ready, 0);

    // mismatches on beats 1 and 2; first one captured
    do_start(16'd3);
    send_beat(12'h111, 4'h7, 4'h7);
    send_beat(12'hA5C, 4'h3, 4'h2);
    send_beat(12'h123, 4'h5, 4'h4);
    check_eq("t2_done", done, 1);
    check_eq("t2_fail_count", fail_count, 2);
    check_eq("t2_ff_idx", first_fail_idx, 1);
    check_eq("t2_ff_vec", first_fail_vec, 12'hA5C);
    check_eq("t2_ff_gold", first_fail_gold, 4'h3);
    check_eq("t2_ff_dut", first_fail_dut, 4'h2);
    check_eq("t2_pass", pass, 0);
    check_eq("t2_signature", signature, 16'h001C);

    // 17 beats of dut_out=1: feedback first applies on beat 17
    do_start(16'd17);
    check_eq("t3_ff_cleared", first_fail_vec, 12'h000);
    for (int i = 0; i < 16; i++) send_beat(12'(i), 4'h1, 4'h1);
    idle_cycle();
    check_eq("t3_sig16", signature, 16'hFFFF);
    check_eq("t3_busy16", busy, 1);
    send_beat(12'h010, 4'h1, 4'h1);
    check_eq("t3_done", done, 1);
    check_eq("t3_sig17", signature, 16'hEFF4);

    // zero-length run
    do_start(16'd0);
    check_eq("t4_done", done, 1);
    check_eq("t4_pass", pass, 1);
    check_eq("t4_signature", signature, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      check_eq("t4_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    check_eq("t4_still_done", done, 1);

    // gapped in_valid, then mid-run start is ignored
    do_start(16'd5);
    send_beat(12'h0F0, 4'h9, 4'h8);
    idle_cycle();
    idle_cycle();
    send_beat(12'h0F1, 4'h2, 4'h2);
    check_eq("t5_fail_count", fail_count, 1);
    check_eq("t5_ff_idx", first_fail_idx, 0);
    do_start(16'd1);
    check_eq("t5_busy_after_start", busy, 1);
    check_eq("t5_fail_kept", fail_count, 1);
    check_eq("t5_ff_vec_kept", first_fail_vec, 12'h0F0);
    send_beat(12'h0F2, 4'h1, 4'h1);
    send_beat(12'h0F3, 4'h1, 4'h1);
    check_eq("t5_not_done_at4", done, 0);
    send_beat(12'h0F4, 4'h1, 4'h1);
    check_eq("t5_done_at5", done, 1);
    check_eq("t5_pass", pass, 0);

    // reset mid-run discards partial result
    do_start(16'd5);
    send_beat(12'h201, 4'h6, 4'h1);
    send_beat(12'h202, 4'h6, 4'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_in_ready", in_ready, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_fail_count", fail_count, 0);
    check_eq("t6_signature", signature, 16'h0000);
    check_eq("t6_ff_idx", first_fail_idx, 0);
    do_start(16'd2);
    send_beat(12'h301, 4'h3, 4'h3);
    send_beat(12'h302, 4'h5, 4'h5);
    check_eq("t6_rerun_done", done, 1);
    check_eq("t6_rerun_pass", pass, 1);
    check_eq("t6_rerun_sig", signature, 16'h0003);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eqv_response_checker.md
Name: eqv_response_checker

Overview:
- Sequential response stage downstream of the simplified combinational netlist (outputs n26, n34, n52, n54) and its golden original.
- Accepts one stimulus beat per handshake, carrying the 12-bit input vector plus both 4-bit responses.
- Counts and records mismatches, captures the first failing vector, and compacts the simplified-circuit responses into a 16-bit MISR signature.
- Reports pass/fail when a programmed vector count has been consumed.

Parameters:
- CNT_W, 16, width of the vector counter, num_vectors and the fail count.
- POLY, 16'h100B, MISR feedback polynomial (x^16+x^12+x^3+x+1, bit 16 implicit).
- SEED, 16'h0000, MISR value loaded on start.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- num_vectors  in  CNT_W  beats to consume; sampled on accepted start
- in_valid  in  1  upstream beat valid
- in_ready  out  1  checker can accept a beat
- in_vec  in  12  stimulus {n66,n65,n64,n61,n58,n46,n32,n27,n13,n10,n4,n1}, MSB first
- gold_out  in  4  golden response {n54,n52,n34,n26}
- dut_out  in  4  simplified response, same bit order
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  valid while done; 1 iff fail_count==0
- fail_count  out  CNT_W  mismatching beats, saturating at all-ones
- first_fail_idx  out  CNT_W  beat index (0-based) of first mismatch
- first_fail_vec  out  12  in_vec of first mismatch
- first_fail_gold  out  4  gold_out of first mismatch
- first_fail_dut  out  4  dut_out of first mismatch
- signature  out  16  MISR state

Behaviour:
- Reset: state IDLE. in_ready, busy, done and pass are 0. fail_count, idx and all first_fail_* fields are 0. signature=SEED. Reset during RUN aborts the run; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start with num_vectors!=0.
  - IDLE -> DONE on start with num_vectors==0; pass=1, signature=SEED.
  - RUN -> DONE on the cycle the accepted beat has idx==num_vectors-1.
  - DONE -> RUN or DONE on start, same rules as IDLE.
  - start during RUN is ignored.
- On accepted start:
  - clear fail_count, idx, first_fail_* and the internal first-seen flag;
  - signature<=SEED;
  - latch num_vectors.
- in_ready is 1 in RUN only; it is a registered state decode with no combinational path from in_valid.
- A beat is transferred when in_valid && in_ready. There is no backpressure inside RUN; every cycle with in_valid=1 transfers.
- Per transferred beat, all updates are registered and visible the next cycle:
  - mismatch = (gold_out != dut_out);
  - fail_count += mismatch, holding at 2^CNT_W-1 once reached;
  - if mismatch and no earlier mismatch: capture idx, in_vec, gold_out, dut_out and set the flag; later mismatches do not overwrite;
  - signature <= {signature[14:0],1'b0} ^ (signature[15] ? POLY : 16'h0) ^ {12'h000, dut_out};
  - idx += 1.
- done rises the cycle after the last beat and holds until the next start or reset. pass is 0 whenever done=0.
- While in_ready=0, in_valid is ignored; no state changes.
- Latency: 1 cycle from beat transfer to counter/signature update.

Test Plan:
- Reset, then start with num_vectors=4 and 4 matching beats with dut_out=gold_out=4'h1,0,0,0 -> done=1 one cycle after beat 3, pass=1, fail_count=0, signature=16'h0008.
- Start, num_vectors=3, mismatch on beat 1 (vec=12'hA5C, gold=4'h3, dut=4'h2) and beat 2 -> fail_count=2, first_fail_idx=1, first_fail_vec=12'hA5C, first_fail_gold=3, first_fail_dut=2, pass=0.
- 17 beats with dut_out=4'h1, SEED=0 -> signature feedback applies at beat 17 (signature[15]=1); check against the reference MISR model value, including POLY term.
- Start with num_vectors=0 -> DONE next cycle, pass=1, in_ready never asserts.
- in_valid toggled 1,0,0,1 during RUN -> only 2 beats counted, idx=2; start pulsed mid-run -> ignored, counters not cleared.
- rst asserted after 2 of 5 beats -> next cycle IDLE, in_ready=0, fail_count=0, signature=SEED; a new start then runs cleanly to done.
